// File: rtl/icache_direct_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_direct_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } icache_state_t;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  localparam int DEF_NUM_LINES  = 8;
  localparam int DEF_LINE_WORDS = 4;

  // Byte-offset bits within a line (word select plus the two byte bits).
  function automatic int off_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int num_lines, input int line_words);
    return 32 - off_bits(line_words) - idx_bits(num_lines);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, data and valid storage: combinational read, synchronous line write and clear-all.
module icache_array
  import icache_direct_pkg::*;
#(
  parameter int  NUM_LINES  = DEF_NUM_LINES,
  parameter int  LINE_WORDS = DEF_LINE_WORDS,
  localparam int IDX_W      = idx_bits(NUM_LINES),
  localparam int TAG_W      = tag_bits(NUM_LINES, LINE_WORDS),
  localparam int LINE_W     = 32 * LINE_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              wr_valid,
  input  logic              clear_all
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // A line write in the same cycle as clear-all keeps its own valid value,
  // so the caller decides whether a refill racing an invalidate survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (clear_all) valid_q <= '0;
      if (wr_en)     valid_q[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped blocking instruction cache with single-beat line refill.
// Optional hit/miss counters are built when ICACHE_PERF_COUNTERS_EN is defined.
//
// Memory handshake: a request transfers in a cycle where mem_req_valid and
// mem_req_ready are both high; mem_req_valid/mem_req_addr stay stable until
// then. mem_resp_valid is only honoured in WAIT and carries the whole line.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int          NUM_LINES  = DEF_NUM_LINES,
  parameter int          LINE_WORDS = DEF_LINE_WORDS,
  parameter logic [31:0] NOP_INST   = icache_direct_pkg::NOP_INST
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_req_valid,
  input  logic [31:0]             in_pc,
  input  logic                    in_invalidate,
  output logic [31:0]             out_inst,
  output logic                    out_inst_valid,
  output logic                    out_stall,
  output logic                    mem_req_valid,
  output logic [31:0]             mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_data,
`ifdef ICACHE_PERF_COUNTERS_EN
  output logic [31:0]             out_hit_count,
  output logic [31:0]             out_miss_count,
`endif
  output icache_state_t           dbg_state
);

  localparam int OFF_W  = off_bits(LINE_WORDS);
  localparam int IDX_W  = idx_bits(NUM_LINES);
  localparam int TAG_W  = tag_bits(NUM_LINES, LINE_WORDS);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int LINE_W = 32 * LINE_WORDS;

  icache_state_t    state_q, state_d;
  logic [31:0]      miss_addr_q;
  logic             inval_pend_q;

  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [WSEL_W-1:0] pc_wsel;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              hit;
  logic              wr_en;
  logic              wr_valid;
  logic              miss_start;
  logic              unused_pc_bits;

  assign pc_idx         = in_pc[OFF_W +: IDX_W];
  assign pc_tag         = in_pc[31 -: TAG_W];
  assign pc_wsel        = in_pc[2 +: WSEL_W];
  assign unused_pc_bits = ^in_pc[1:0];

  assign hit = in_req_valid && rd_valid && (rd_tag == pc_tag);

  // An invalidate seen anywhere during the refill, or on the response edge,
  // makes the refilled line land invalid.
  assign wr_valid = !(inval_pend_q || in_invalidate);

  icache_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pc_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_idx    (miss_addr_q[OFF_W +: IDX_W]),
    .wr_tag    (miss_addr_q[31 -: TAG_W]),
    .wr_line   (mem_resp_data),
    .wr_valid  (wr_valid),
    .clear_all (in_invalidate && !reset)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      inval_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        miss_addr_q  <= {in_pc[31:OFF_W], {OFF_W{1'b0}}};
        inval_pend_q <= 1'b0;
      end else if (in_invalidate && (state_q != IDLE)) begin
        inval_pend_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    out_stall      = 1'b0;
    out_inst_valid = 1'b0;
    out_inst       = NOP_INST;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    wr_en          = 1'b0;
    miss_start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_req_valid) begin
          if (hit) begin
            out_inst_valid = 1'b1;
            out_inst       = rd_line[32*pc_wsel +: 32];
          end else begin
            out_stall  = 1'b1;
            miss_start = 1'b1;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        out_stall     = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = miss_addr_q;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        out_stall = 1'b1;
        if (mem_resp_valid) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset forces idle-looking outputs even while a refill was in flight.
    if (reset) begin
      out_stall      = 1'b0;
      out_inst_valid = 1'b0;
      out_inst       = NOP_INST;
      mem_req_valid  = 1'b0;
      mem_req_addr   = '0;
      wr_en          = 1'b0;
      miss_start     = 1'b0;
    end
  end

  assign dbg_state = state_q;

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (out_inst_valid) hit_count_q  <= hit_count_q + 32'd1;
      if (miss_start)     miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign out_hit_count  = hit_count_q;
  assign out_miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed refill scenarios plus randomized traffic
// checked every cycle against a line-level behavioural model.
module tb_icache_direct;
  import icache_direct_pkg::*;

  localparam int NL = 8;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_req_valid;
  logic [31:0]     in_pc;
  logic            in_invalidate;
  logic [31:0]     out_inst;
  logic            out_inst_valid;
  logic            out_stall;
  logic            mem_req_valid;
  logic [31:0]     mem_req_addr;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [32*LW-1:0] mem_resp_data;
  icache_state_t   dbg_state;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0]     out_hit_count;
  logic [31:0]     out_miss_count;
`endif

  icache_direct #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_req_valid   (in_req_valid),
    .in_pc          (in_pc),
    .in_invalidate  (in_invalidate),
    .out_inst       (out_inst),
    .out_inst_valid (out_inst_valid),
    .out_stall      (out_stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
`ifdef ICACHE_PERF_COUNTERS_EN
    .out_hit_count  (out_hit_count),
    .out_miss_count (out_miss_count),
`endif
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cache contents per index, plus a record of the single outstanding refill.
  bit          m_valid [NL];
  logic [24:0] m_tag   [NL];
  logic [31:0] m_line  [NL][LW];
  bit          m_busy, m_issued, m_inval;
  logic [31:0] m_addr;
  int          m_cnt;
  int unsigned m_hits, m_misses;

  int rdy_force      = -1;
  int resp_delay_fix = -1;
  bit resp_force     = 1'b0;
  bit spur_en        = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic bit model_hit();
    return in_req_valid && !m_busy && m_valid[in_pc[6:4]] && (m_tag[in_pc[6:4]] == in_pc[31:7]);
  endfunction

  always @(posedge clk) begin : model
    bit h, was_busy;
    h = model_hit();
    was_busy = m_busy;
    if (reset) begin
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      m_busy = 0; m_issued = 0; m_inval = 0; m_hits = 0; m_misses = 0;
    end else begin
      if (h) m_hits++;
      if (in_invalidate) for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      if (m_busy && m_issued) begin
        if (mem_resp_valid) begin
          for (int w = 0; w < LW; w++) m_line[m_addr[6:4]][w] = mem_resp_data[32*w +: 32];
          m_tag[m_addr[6:4]]   = m_addr[31:7];
          m_valid[m_addr[6:4]] = !(m_inval || in_invalidate);
          m_busy = 0;
        end else begin
          m_cnt--;
        end
      end else if (m_busy && mem_req_ready) begin
        m_issued = 1;
        m_cnt = (resp_delay_fix > 0) ? resp_delay_fix : $urandom_range(1, 4);
      end
      if (m_busy && in_invalidate) m_inval = 1;
      if (!was_busy && in_req_valid && !h) begin
        m_busy = 1; m_issued = 0; m_inval = 0;
        m_addr = {in_pc[31:4], 4'b0000};
        m_misses++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    bit eh;
    bit e_stall, e_mreq;
    logic [31:0] e_inst, e_addr;
    if (chk_en) begin
      eh      = !reset && model_hit();
      e_stall = !reset && (m_busy || (in_req_valid && !eh));
      e_inst  = eh ? m_line[in_pc[6:4]][in_pc[3:2]] : NOP_INST;
      e_mreq  = !reset && m_busy && !m_issued;
      e_addr  = e_mreq ? m_addr : 32'h0;
      chk("out_stall", {31'b0, out_stall}, {31'b0, e_stall});
      chk("out_inst_valid", {31'b0, out_inst_valid}, {31'b0, eh});
      chk("out_inst", out_inst, e_inst);
      chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, e_mreq});
      chk("mem_req_addr", mem_req_addr, e_addr);
`ifdef ICACHE_PERF_COUNTERS_EN
      chk("out_hit_count", out_hit_count, m_hits);
      chk("out_miss_count", out_miss_count, m_misses);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit rst, input bit req, input logic [31:0] pc, input bit inv);
    @(posedge clk);
    #1;
    reset         = rst;
    in_req_valid  = req;
    in_pc         = pc;
    in_invalidate = inv;
    mem_req_ready = (rdy_force >= 0) ? rdy_force[0] : 1'($urandom_range(0, 1));
    if (m_busy && m_issued) begin
      mem_resp_valid = (m_cnt <= 1);
      for (int w = 0; w < LW; w++) mem_resp_data[32*w +: 32] = mem_word(m_addr + 32'(4*w));
    end else begin
      mem_resp_valid = resp_force || (spur_en && ($urandom_range(0, 9) == 0));
      for (int w = 0; w < LW; w++) mem_resp_data[32*w +: 32] = $urandom;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic run_to_hit(input logic [31:0] pc, input int budget);
    int n;
    n = 0;
    do begin
      cyc(0, 1, pc, 0);
      n++;
    end while (!out_inst_valid && n < budget);
    chk("refill_done", {31'b0, out_inst_valid}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pc;
    reset = 1; in_req_valid = 0; in_pc = 0; in_invalidate = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;

    cyc(1, 0, 0, 0);
    chk_en = 1;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_stall", {31'b0, out_stall}, 32'd0);
    chk("rst_inst_valid", {31'b0, out_inst_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'h00000013);
    chk("rst_mreq", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_maddr", mem_req_addr, 32'd0);

    // Cold miss with fixed handshake timing
    rdy_force = 0; resp_delay_fix = 3;
    cyc(0, 1, 32'h100, 0);
    chk("cold_stall", {31'b0, out_stall}, 32'd1);
    cyc(0, 1, 32'h100, 0);
    chk("cold_mreq", {31'b0, mem_req_valid}, 32'd1);
    chk("cold_maddr", mem_req_addr, 32'h100);
    rdy_force = 1;
    cyc(0, 1, 32'h100, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h100, 0);
    cyc(0, 1, 32'h100, 0);
    chk("cold_inst", out_inst, 32'h00500093);
    chk("cold_valid", {31'b0, out_inst_valid}, 32'd1);
    chk("cold_nostall", {31'b0, out_stall}, 32'd0);

    // Same-line hits
    cyc(0, 1, 32'h104, 0);
    chk("hit_104", out_inst, 32'h0104FEFB);
    cyc(0, 1, 32'h108, 0);
    chk("hit_108", out_inst, 32'h0108FEF7);
    cyc(0, 1, 32'h10C, 0);
    chk("hit_10c", out_inst, 32'h010CFEF3);
    chk("hit_nomreq", {31'b0, mem_req_valid}, 32'd0);
    cyc(0, 0, 0, 0);
`ifdef ICACHE_PERF_COUNTERS_EN
    chk("perf_hits", out_hit_count, 32'd4);
    chk("perf_misses", out_miss_count, 32'd1);
`endif

    // Conflict eviction on index 0
    rdy_force = -1; resp_delay_fix = -1;
    cyc(0, 1, 32'h180, 0);
    chk("conflict_stall", {31'b0, out_stall}, 32'd1);
    run_to_hit(32'h180, 20);
    cyc(0, 1, 32'h100, 0);
    chk("evicted_stall", {31'b0, out_stall}, 32'd1);
    run_to_hit(32'h100, 20);

    // Invalidate during WAIT
    rdy_force = 1; resp_delay_fix = 3;
    cyc(0, 1, 32'h200, 0);
    cyc(0, 1, 32'h200, 0);
    cyc(0, 1, 32'h200, 1);
    cyc(0, 1, 32'h200, 0);
    cyc(0, 1, 32'h200, 0);
    cyc(0, 1, 32'h200, 0);
    chk("inval_relookup_stall", {31'b0, out_stall}, 32'd1);
    chk("inval_relookup_valid", {31'b0, out_inst_valid}, 32'd0);
    cyc(0, 1, 32'h200, 0);
    chk("inval_rereq", {31'b0, mem_req_valid}, 32'd1);
    chk("inval_rereq_addr", mem_req_addr, 32'h200);
    run_to_hit(32'h200, 20);

    // Reset mid-REQ, then a late response
    rdy_force = 0; resp_delay_fix = -1;
    cyc(0, 1, 32'h300, 0);
    cyc(0, 1, 32'h300, 0);
    chk("midreq_mreq", {31'b0, mem_req_valid}, 32'd1);
    cyc(1, 0, 32'h300, 0);
    resp_force = 1;
    cyc(0, 0, 32'h300, 0);
    chk("post_rst_mreq", {31'b0, mem_req_valid}, 32'd0);
    resp_force = 0;
    cyc(0, 1, 32'h300, 0);
    chk("post_rst_miss", {31'b0, out_stall}, 32'd1);
    rdy_force = -1;
    run_to_hit(32'h300, 20);

    // Randomized traffic over a small address pool to force conflicts
    spur_en = 1;
    for (int i = 0; i < 2500; i++) begin
      pc = {23'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 2'b00};
      pc = pc << 2 | 32'($urandom_range(0, 3));
      cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 9) < 8), pc,
          ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
